// File: rtl/mpeg_pes_muxer.sv
// mpeg_pes_muxer: builds an MPEG-1 system stream one byte at a time.
// Per request it emits an optional 12-byte pack header, one PES header
// (start code, length, PTS/DTS or 0x0F), the elementary payload pulled from in_*,
// and an optional program end code. The output is a single registered byte stage.
// Ports:
//   clk_i, reset_i               clock, synchronous active-high reset
//   req_*_i / req_ready_o        packet request, taken when valid && ready (IDLE only)
//   in_data_i/in_valid_i/in_ready_o   payload byte stream
//   out_data_o/out_valid_o/out_ready_i  muxed byte stream
//   busy_o                       FSM not idle
//   packet_done_o                pulse when the sink accepts the final byte of a request
//   req_error_o                  pulse when a request is rejected
module mpeg_pes_muxer #(
  parameter bit StrictStreamId = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_pack_i,
  input  logic [32:0] req_scr_i,
  input  logic [21:0] req_mux_rate_i,
  input  logic [7:0]  req_stream_id_i,
  input  logic        req_pts_en_i,
  input  logic        req_dts_en_i,
  input  logic [32:0] req_pts_i,
  input  logic [32:0] req_dts_i,
  input  logic [15:0] req_payload_len_i,
  input  logic        req_end_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        packet_done_o,
  output logic        req_error_o
);

  typedef enum logic [2:0] {StIdle, StPack, StPesHdr, StPayload, StEnd} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        last_q, last_d;  // output register holds the final byte of a request

  // Request fields latched at accept
  logic [32:0] scr_q, pts_q, dts_q;
  logic [21:0] mr_q;
  logic [7:0]  sid_q;
  logic        pts_en_q, dts_en_q, end_q;
  logic [15:0] len_q;

  logic        load, accept, req_bad, sid_ok;
  logic [3:0]  req_hdr_len, hdr_len, pes_last;
  logic [16:0] req_total;
  logic [15:0] pes_len;
  logic [7:0]  hdr_byte;
  logic [32:0] ts;
  logic [3:0]  ts_pfx, ts_idx;

  assign load        = !out_valid_q || out_ready_i;
  assign accept      = req_valid_i && (state_q == StIdle);
  assign req_hdr_len = req_pts_en_i ? (req_dts_en_i ? 4'd10 : 4'd5) : 4'd1;
  assign req_total   = {1'b0, req_payload_len_i} + 17'(req_hdr_len);
  assign sid_ok      = !StrictStreamId || (req_stream_id_i[7:4] == 4'hC) ||
                       (req_stream_id_i[7:4] == 4'hE);
  assign req_bad     = (req_dts_en_i && !req_pts_en_i) || !sid_ok || req_total[16];

  assign hdr_len  = pts_en_q ? (dts_en_q ? 4'd10 : 4'd5) : 4'd1;
  assign pes_len  = 16'(hdr_len) + len_q;
  assign pes_last = 4'd5 + hdr_len;

  // Header byte for the current state/index
  always_comb begin
    hdr_byte = 8'h00;
    if (cnt_q >= 4'd11) begin
      ts     = dts_q;
      ts_pfx = 4'b0001;
      ts_idx = cnt_q - 4'd11;
    end else begin
      ts     = pts_q;
      ts_pfx = dts_en_q ? 4'b0011 : 4'b0010;
      ts_idx = cnt_q - 4'd6;
    end
    case (state_q)
      StPack: begin
        case (cnt_q)
          4'd2:    hdr_byte = 8'h01;
          4'd3:    hdr_byte = 8'hBA;
          4'd4:    hdr_byte = {4'b0010, scr_q[32:30], 1'b1};
          4'd5:    hdr_byte = scr_q[29:22];
          4'd6:    hdr_byte = {scr_q[21:15], 1'b1};
          4'd7:    hdr_byte = scr_q[14:7];
          4'd8:    hdr_byte = {scr_q[6:0], 1'b1};
          4'd9:    hdr_byte = {1'b1, mr_q[21:15]};
          4'd10:   hdr_byte = mr_q[14:7];
          4'd11:   hdr_byte = {mr_q[6:0], 1'b1};
          default: hdr_byte = 8'h00;
        endcase
      end
      StPesHdr: begin
        case (cnt_q)
          4'd0, 4'd1: hdr_byte = 8'h00;
          4'd2:       hdr_byte = 8'h01;
          4'd3:       hdr_byte = sid_q;
          4'd4:       hdr_byte = pes_len[15:8];
          4'd5:       hdr_byte = pes_len[7:0];
          default: begin
            if (!pts_en_q) begin
              hdr_byte = 8'h0F;
            end else begin
              case (ts_idx)
                4'd0:    hdr_byte = {ts_pfx, ts[32:30], 1'b1};
                4'd1:    hdr_byte = ts[29:22];
                4'd2:    hdr_byte = {ts[21:15], 1'b1};
                4'd3:    hdr_byte = ts[14:7];
                default: hdr_byte = {ts[6:0], 1'b1};
              endcase
            end
          end
        endcase
      end
      StEnd: begin
        case (cnt_q)
          4'd2:    hdr_byte = 8'h01;
          4'd3:    hdr_byte = 8'hB9;
          default: hdr_byte = 8'h00;
        endcase
      end
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pay_cnt_d   = pay_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    in_ready_o  = (state_q == StPayload) && load;
    if (load) out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && !req_bad) begin
          state_d   = req_pack_i ? StPack : StPesHdr;
          pay_cnt_d = req_payload_len_i;
          cnt_d     = 4'd0;
          // Both headers open with 0x00, so it can be loaded in the accept cycle
          if (load) begin
            out_data_d  = 8'h00;
            out_valid_d = 1'b1;
            last_d      = 1'b0;
            cnt_d       = 4'd1;
          end
        end
      end
      StPack, StPesHdr, StEnd: begin
        if (load) begin
          out_data_d  = hdr_byte;
          out_valid_d = 1'b1;
          last_d      = 1'b0;
          cnt_d       = cnt_q + 4'd1;
          if (state_q == StPack && cnt_q == 4'd11) begin
            state_d = StPesHdr;
            cnt_d   = 4'd0;
          end else if (state_q == StPesHdr && cnt_q == pes_last) begin
            cnt_d = 4'd0;
            if (len_q != 16'd0) begin
              state_d = StPayload;
            end else if (end_q) begin
              state_d = StEnd;
            end else begin
              state_d = StIdle;
              last_d  = 1'b1;
            end
          end else if (state_q == StEnd && cnt_q == 4'd3) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            last_d  = 1'b1;
          end
        end
      end
      StPayload: begin
        if (in_valid_i && load) begin
          out_data_d  = in_data_i;
          out_valid_d = 1'b1;
          last_d      = 1'b0;
          pay_cnt_d   = pay_cnt_q - 16'd1;
          if (pay_cnt_q == 16'd1) begin
            state_d = end_q ? StEnd : StIdle;
            last_d  = !end_q;
            cnt_d   = 4'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      pay_cnt_q   <= 16'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && !req_bad) begin
      scr_q    <= req_scr_i;
      mr_q     <= req_mux_rate_i;
      sid_q    <= req_stream_id_i;
      pts_en_q <= req_pts_en_i;
      dts_en_q <= req_dts_en_i;
      pts_q    <= req_pts_i;
      dts_q    <= req_dts_i;
      len_q    <= req_payload_len_i;
      end_q    <= req_end_i;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign req_error_o   = accept && req_bad;
  assign busy_o        = (state_q != StIdle);
  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign packet_done_o = out_valid_q && out_ready_i && last_q;

endmodule
